rx_frame_parser: RTL



---
 rtl/rx_frame_parser.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/rx_frame_parser.sv
// Host-to-radio frame parser: pops 16-bit words from the Rx FIFO, locks on 7F7F/7Fxx sync,
// commits the five C&C bytes atomically and hands out 64-bit {L,R,I,Q} samples over rdy/ack.
module rx_frame_parser #(
  parameter int RX_FIFO_SZ = 2048,
  parameter int NUM_LOOPS  = 63,
  parameter int IF_TPD     = 1,
  localparam int RFSZ      = $clog2(RX_FIFO_SZ)
) (
  input  logic            IF_clk,
  input  logic            IF_reset,
  input  logic [15:0]     Rx_fifo_rdata,
  input  logic            Rx_fifo_empty,
  input  logic [RFSZ-1:0] Rx_fifo_used,
  output logic            Rx_fifo_rreq,
  output logic [7:0]      C0,
  output logic [7:0]      C1,
  output logic [7:0]      C2,
  output logic [7:0]      C3,
  output logic [7:0]      C4,
  output logic            cc_valid,
  output logic [63:0]     sample_data,
  output logic            sample_rdy,
  input  logic            sample_ack,
  output logic            in_sync,
  output logic [7:0]      sync_err_cnt
);

  localparam logic [15:0] SYNC_WORD = 16'h7F7F;
  localparam logic [7:0]  SYNC_BYTE = 8'h7F;
  localparam int          LW        = $clog2(NUM_LOOPS + 1);

  typedef enum logic [2:0] {
    HUNT1, HUNT2, CTL12, CTL34, DATA, SAMPLE_OUT, SYNC1
  } state_t;

  state_t        r_state;
  logic [LW-1:0] r_loop;
  logic [1:0]    r_widx;
  logic [47:0]   r_asm;
  logic [7:0]    r_c0_stg, r_c1_stg, r_c2_stg;
  logic [7:0]    r_c0, r_c1, r_c2, r_c3, r_c4;
  logic          r_cc_valid;
  logic [63:0]   r_sample_data;
  logic          r_sample_rdy;
  logic          r_in_sync;
  logic [7:0]    r_sync_err_cnt;

  logic          w_pop;
  logic [LW-1:0] w_loop_next;
  logic [7:0]    w_err_next;
  logic          w_unused;

  // Every state except SAMPLE_OUT consumes the head word whenever one is present.
  assign w_pop        = (r_state != SAMPLE_OUT) && !Rx_fifo_empty;
  assign Rx_fifo_rreq = w_pop;
  assign w_loop_next  = r_loop + 1'b1;
  assign w_err_next   = (r_sync_err_cnt == 8'hFF) ? r_sync_err_cnt : r_sync_err_cnt + 8'd1;

  // Fill level is status only and no simulation delays are modelled.
  assign w_unused = ^{Rx_fifo_used, (IF_TPD != 0)};

  // NOTE: every state register uses non-blocking assignment so all decisions on an edge
  // see pre-edge values; r_cc_valid defaults low each cycle to form a one-cycle pulse.
  always_ff @(posedge IF_clk) begin
    if (IF_reset) begin
      r_state        <= HUNT1;
      r_loop         <= '0;
      r_widx         <= '0;
      r_asm          <= '0;
      r_c0_stg       <= '0;
      r_c1_stg       <= '0;
      r_c2_stg       <= '0;
      r_c0           <= '0;
      r_c1           <= '0;
      r_c2           <= '0;
      r_c3           <= '0;
      r_c4           <= '0;
      r_cc_valid     <= 1'b0;
      r_sample_data  <= '0;
      r_sample_rdy   <= 1'b0;
      r_in_sync      <= 1'b0;
      r_sync_err_cnt <= '0;
    end else begin
      r_cc_valid <= 1'b0;
      case (r_state)
        HUNT1: begin
          if (w_pop && Rx_fifo_rdata == SYNC_WORD) r_state <= HUNT2;
        end
        HUNT2: begin
          if (w_pop) begin
            if (Rx_fifo_rdata[15:8] == SYNC_BYTE) begin
              r_c0_stg <= Rx_fifo_rdata[7:0];
              r_state  <= CTL12;
            end else begin
              if (r_in_sync) begin
                r_in_sync      <= 1'b0;
                r_sync_err_cnt <= w_err_next;
              end
              r_state <= HUNT1;
            end
          end
        end
        CTL12: begin
          if (w_pop) begin
            r_c1_stg <= Rx_fifo_rdata[15:8];
            r_c2_stg <= Rx_fifo_rdata[7:0];
            r_state  <= CTL34;
          end
        end
        CTL34: begin
          // All five bytes become visible on the same edge, never piecemeal.
          if (w_pop) begin
            r_c0       <= r_c0_stg;
            r_c1       <= r_c1_stg;
            r_c2       <= r_c2_stg;
            r_c3       <= Rx_fifo_rdata[15:8];
            r_c4       <= Rx_fifo_rdata[7:0];
            r_cc_valid <= 1'b1;
            r_in_sync  <= 1'b1;
            r_loop     <= '0;
            r_widx     <= '0;
            r_state    <= DATA;
          end
        end
        DATA: begin
          if (w_pop) begin
            r_widx <= r_widx + 2'd1;
            if (r_widx == 2'd3) begin
              r_sample_data <= {r_asm, Rx_fifo_rdata};
              r_sample_rdy  <= 1'b1;
              r_state       <= SAMPLE_OUT;
            end else begin
              r_asm <= {r_asm[31:0], Rx_fifo_rdata};
            end
          end
        end
        SAMPLE_OUT: begin
          if (sample_ack) begin
            r_sample_rdy <= 1'b0;
            r_loop       <= w_loop_next;
            r_state      <= (w_loop_next == LW'(NUM_LOOPS)) ? SYNC1 : DATA;
          end
        end
        SYNC1: begin
          if (w_pop) begin
            if (Rx_fifo_rdata == SYNC_WORD) begin
              r_state <= HUNT2;
            end else begin
              r_in_sync      <= 1'b0;
              r_sync_err_cnt <= w_err_next;
              r_state        <= HUNT1;
            end
          end
        end
        default: r_state <= HUNT1;
      endcase
    end
  end

  assign C0           = r_c0;
  assign C1           = r_c1;
  assign C2           = r_c2;
  assign C3           = r_c3;
  assign C4           = r_c4;
  assign cc_valid     = r_cc_valid;
  assign sample_data  = r_sample_data;
  assign sample_rdy   = r_sample_rdy;
  assign in_sync      = r_in_sync;
  assign sync_err_cnt = r_sync_err_cnt;

endmodule
